axi_burst_addrgen: RTL and testbench
====================================

# axi_burst_addrgen

Sequential AXI burst address generator: accepts one AW/AR-style burst descriptor (address, length, size, burst type) and emits one address beat per cycle, with byte strobe and last flag, under valid/ready backpressure. It generalises the single-step next-address calculator to whole bursts. It adds parametrised length width (AXI3/AXI4), narrow and unaligned-start handling, and protocol-error detection. It sits behind the AW/AR skid buffer in slave and bridge cores and drives the per-beat datapath.

## Interface

- AW, 32, address width (≥ 12)
- DW, 32, data width in bits (power of two, 8..1024); DSZ = log2(DW/8)
- LGLEN, 8, length field width (8 = AXI4, 4 = AXI3)
- OPT_LOWPOWER, 0, when 1, beat outputs are forced to zero whenever o_beat_valid is low

- i_clk  input  1  single clock; all logic on its rising edge
- i_reset  input  1  synchronous, active-high reset
- i_req_valid  input  1  burst descriptor valid
- o_req_ready  output  1  descriptor accepted when i_req_valid && o_req_ready
- i_req_addr  input  AW  start address
- i_req_len  input  LGLEN  beats minus one
- i_req_size  input  3  log2 bytes per beat
- i_req_burst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- o_req_err  output  1  one-cycle pulse: the accepted descriptor was illegal and produces no beats
- o_beat_valid  output  1  beat valid
- i_beat_ready  input  1  beat consumed when o_beat_valid && i_beat_ready
- o_beat_addr  output  AW  address of this beat
- o_beat_strb  output  DW/8  active byte lanes of this beat
- o_beat_last  output  1  final beat of the burst

## Operation

- States: IDLE (no beat pending) and BURST (o_beat_valid=1).
- o_req_ready = !o_beat_valid || (i_beat_ready && o_beat_last). This is the only combinational input-to-output path.
- Illegal descriptors are accepted, pulse o_req_err, and leave the block in IDLE:
  - burst == 11
  - size > DSZ
  - WRAP with len not in {1,3,7,15}
  - WRAP with addr not size-aligned
  - INCR where aligned(addr) + ((len+1) << size) - 1 crosses a 4 KiB boundary. Compute this without truncation: at least LGLEN+8+12 bits.
- Legal descriptor: load address, size, burst and beats-remaining counter (= len); enter BURST.
- First beat: o_beat_addr = i_req_addr exactly, including unaligned low bits.
- Next-beat address, with B = 1 << size:
  - FIXED: unchanged.
  - INCR: (addr & ~(B-1)) + B, computed in bits [11:0] only; bits [AW-1:12] held.
  - WRAP: with M = (len+1)*B - 1, next = (addr & ~M) | ((addr + B) & M).
- Strobe:
  - Lanes from addr mod (DW/8) through the last byte of the B-aligned container containing addr.
  - Unaligned INCR/FIXED beats mask the lower lanes.
  - Aligned beats set B lanes.
- o_beat_last = 1 when beats-remaining == 0.
- On the last-beat handshake:
  - With a simultaneous request accepted: load the new descriptor (BURST continues, or err pulse → IDLE).
  - Otherwise: enter IDLE.

## Timing

- Reset values:
  - o_req_ready = 1
  - o_req_err = 0
  - o_beat_valid = 0
  - o_beat_addr = 0
  - o_beat_strb = 0
  - o_beat_last = 0
- Request accepted at cycle N:
  - Legal: first beat valid at N+1.
  - Illegal: o_req_err = 1 at N+1 only, with o_beat_valid = 0.
- Each beat handshake advances to the next beat in the following cycle. The full burst streams at 1 beat/cycle with i_beat_ready held high.
- Back-to-back bursts: zero idle cycles between the last beat of one burst and the first beat of the next.
- While o_beat_valid && !i_beat_ready, all beat outputs hold stable.
- Reset mid-burst abandons the burst: outputs take their reset values the next cycle, and no further beats appear.
- OPT_LOWPOWER=0: beat address/strb/last are don't-care while o_beat_valid is low.

## Test plan

All scenarios use DW=32, AW=32, LGLEN=8.

1. INCR aligned: addr 0x1000, len 3, size 2, ready high. Response: addresses 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles from N+1; strb 4'hF each; last only on 0x100C.
2. INCR narrow unaligned: addr 0x2003, len 2, size 1. Response: beats 0x2003/4'b1000, 0x2004/4'b0011, 0x2006/4'b1100.
3. WRAP: addr 0x30C8, len 3, size 2. Response: beats 0x30C8, 0x30CC, 0x30C0, 0x30C4; last on 0x30C4. Repeat with i_beat_ready toggling 1/0 and check outputs stay stable while stalled.
4. FIXED: addr 0x4002, len 2, size 0. Response: 0x4002 three times, strb 4'b0100, last on the third beat.
5. Errors, each giving a one-cycle o_req_err and no beats:
   - burst = 11
   - size = 3
   - INCR 0x0FF8, len 3, size 2 (crosses 0x1000)
   - WRAP len 2
   - WRAP 0x3002, size 2
6. Back-to-back and reset: new request presented during the last beat of scenario 1. Response: its first beat follows on the very next cycle. Then assert i_reset during beat 2 of a len-7 burst: beat_valid = 0 the next cycle and o_req_ready = 1.

Source files
------------

// File: rtl/axi_burst_addrgen.sv
// AXI burst address generator: one descriptor in, one address/strobe/last beat per cycle out.
// Illegal descriptors are swallowed with a one-cycle o_req_err pulse and produce no beats.
module axi_burst_addrgen #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int LGLEN        = 8,
  parameter int OPT_LOWPOWER = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [AW-1:0]     i_req_addr,
  input  logic [LGLEN-1:0]  i_req_len,
  input  logic [2:0]        i_req_size,
  input  logic [1:0]        i_req_burst,
  output logic              o_req_err,
  output logic              o_beat_valid,
  input  logic              i_beat_ready,
  output logic [AW-1:0]     o_beat_addr,
  output logic [DW/8-1:0]   o_beat_strb,
  output logic              o_beat_last
);
  localparam int NB  = DW / 8;
  localparam int DSZ = $clog2(NB);
  localparam int EW  = AW + LGLEN + 8;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic [NB-1:0]    r_strb;
  logic             r_last;
  logic             r_err;
  logic [LGLEN-1:0] r_cnt;
  logic [LGLEN-1:0] r_len;
  logic [2:0]       r_size;
  logic [1:0]       r_burst;

  // Lanes from the start byte up to the end of the size-aligned container holding it.
  function automatic logic [NB-1:0] f_strb(input logic [11:0] a, input logic [2:0] sz);
    logic [11:0] lo, base, hi;
    lo   = a & 12'(NB - 1);
    base = lo & ~((12'd1 << sz) - 12'd1);
    hi   = base + (12'd1 << sz) - 12'd1;
    for (int i = 0; i < NB; i++)
      f_strb[i] = (12'(i) >= lo) && (12'(i) <= hi);
  endfunction

  logic           w_req_fire;
  logic [11:0]    w_req_bmask;
  logic [EW-1:0]  w_aligned;
  logic [EW-1:0]  w_end;
  logic           w_cross;
  logic           w_wrap_len_ok;
  logic           w_illegal;

  assign o_req_ready = (r_state == IDLE) || (i_beat_ready && r_last);
  assign w_req_fire  = i_req_valid && o_req_ready;

  // 4 KiB check is done in a width that cannot overflow for any len/size.
  assign w_req_bmask   = (12'd1 << i_req_size) - 12'd1;
  assign w_aligned     = EW'(i_req_addr) & ~EW'(w_req_bmask);
  assign w_end         = w_aligned + ((EW'(i_req_len) + EW'(1)) << i_req_size) - EW'(1);
  assign w_cross       = (w_end[EW-1:12] != w_aligned[EW-1:12]);
  assign w_wrap_len_ok = (i_req_len == LGLEN'(1)) || (i_req_len == LGLEN'(3)) ||
                         (i_req_len == LGLEN'(7)) || (i_req_len == LGLEN'(15));
  assign w_illegal = (i_req_burst == 2'b11) || (i_req_size > 3'(DSZ)) ||
                     ((i_req_burst == BURST_WRAP) &&
                      (!w_wrap_len_ok || ((i_req_addr[11:0] & w_req_bmask) != 12'd0))) ||
                     ((i_req_burst == BURST_INCR) && w_cross);

  logic [11:0]   w_bsz;
  logic [11:0]   w_incr_lo;
  logic [AW-1:0] w_wmask;
  logic [AW-1:0] w_next;

  assign w_bsz     = 12'd1 << r_size;
  assign w_incr_lo = (r_addr[11:0] & ~(w_bsz - 12'd1)) + w_bsz;
  assign w_wmask   = ((AW'(r_len) + AW'(1)) << r_size) - AW'(1);

  always_comb begin
    w_next = r_addr;
    case (r_burst)
      BURST_INCR:  w_next = (r_addr & ~AW'(12'hFFF)) | AW'(w_incr_lo);
      BURST_WRAP:  w_next = (r_addr & ~w_wmask) | ((r_addr + AW'(w_bsz)) & w_wmask);
      default:     w_next = r_addr;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_strb  <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= BURST_FIXED;
    end else begin
      r_err <= 1'b0;
      if (w_req_fire) begin
        if (w_illegal) begin
          r_err   <= 1'b1;
          r_state <= IDLE;
          if (OPT_LOWPOWER != 0) begin
            r_addr <= '0;
            r_strb <= '0;
            r_last <= 1'b0;
          end
        end else begin
          r_state <= BURST;
          r_addr  <= i_req_addr;
          r_strb  <= f_strb(i_req_addr[11:0], i_req_size);
          r_last  <= (i_req_len == '0);
          r_cnt   <= i_req_len;
          r_len   <= i_req_len;
          r_size  <= i_req_size;
          r_burst <= i_req_burst;
        end
      end else if ((r_state == BURST) && i_beat_ready) begin
        if (r_last) begin
          r_state <= IDLE;
          if (OPT_LOWPOWER != 0) begin
            r_addr <= '0;
            r_strb <= '0;
            r_last <= 1'b0;
          end
        end else begin
          r_addr <= w_next;
          r_strb <= f_strb(w_next[11:0], r_size);
          r_cnt  <= r_cnt - LGLEN'(1);
          r_last <= (r_cnt == LGLEN'(1));
        end
      end
    end
  end

  assign o_req_err    = r_err;
  assign o_beat_valid = (r_state == BURST);
  assign o_beat_addr  = r_addr;
  assign o_beat_strb  = r_strb;
  assign o_beat_last  = r_last;

endmodule

// File: tb/tb_axi_burst_addrgen.sv
// Directed, table-driven bench for axi_burst_addrgen (DW=32, AW=32, LGLEN=8).
module tb_axi_burst_addrgen;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_addr = '0;
  logic [7:0]  i_req_len = '0;
  logic [2:0]  i_req_size = '0;
  logic [1:0]  i_req_burst = '0;
  logic        o_req_err;
  logic        o_beat_valid;
  logic        i_beat_ready = 1'b1;
  logic [31:0] o_beat_addr;
  logic [3:0]  o_beat_strb;
  logic        o_beat_last;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  axi_burst_addrgen #(.AW(32), .DW(32), .LGLEN(8), .OPT_LOWPOWER(0)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_len(i_req_len),
    .i_req_size(i_req_size), .i_req_burst(i_req_burst),
    .o_req_err(o_req_err), .o_beat_valid(o_beat_valid),
    .i_beat_ready(i_beat_ready), .o_beat_addr(o_beat_addr),
    .o_beat_strb(o_beat_strb), .o_beat_last(o_beat_last)
  );

  typedef struct packed {
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              err;
    logic [3:0]        nb;
    logic [3:0][31:0]  ea;
    logic [3:0][3:0]   es;
  } vec_t;

  vec_t v [10];

  function automatic vec_t mk(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic err, input logic [3:0] nb,
                              input logic [31:0] a0, a1, a2, a3,
                              input logic [3:0] s0, s1, s2, s3);
    vec_t r;
    r.addr = addr; r.len = len; r.size = size; r.burst = burst;
    r.err = err; r.nb = nb;
    r.ea[0] = a0; r.ea[1] = a1; r.ea[2] = a2; r.ea[3] = a3;
    r.es[0] = s0; r.es[1] = s1; r.es[2] = s2; r.es[3] = s3;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t d);
    i_req_addr  = d.addr;
    i_req_len   = d.len;
    i_req_size  = d.size;
    i_req_burst = d.burst;
    i_req_valid = 1'b1;
  endtask

  // Present a descriptor at a negedge and hold it until accepted.
  task automatic send(input vec_t d);
    int n;
    @(negedge i_clk);
    drive_req(d);
    n = 0;
    #1;
    while (!o_req_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 20) chk("req_ready_timeout", 32'd0, 32'd1);
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
  endtask

  task automatic expect_beat(input vec_t d, input int b);
    @(negedge i_clk);
    chk("beat_valid", 32'(o_beat_valid), 32'd1);
    chk("beat_addr",  o_beat_addr, d.ea[b]);
    chk("beat_strb",  32'(o_beat_strb), 32'(d.es[b]));
    chk("beat_last",  32'(o_beat_last), 32'(b == int'(d.nb) - 1));
    chk("req_ready_mid", 32'(o_req_ready), 32'(b == int'(d.nb) - 1));
    chk("req_err_mid", 32'(o_req_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc;
    v[0] = mk(32'h1000, 8'd3, 3'd2, 2'b01, 1'b0, 4'd4,
              32'h1000, 32'h1004, 32'h1008, 32'h100C, 4'hF, 4'hF, 4'hF, 4'hF);
    v[1] = mk(32'h2003, 8'd2, 3'd1, 2'b01, 1'b0, 4'd3,
              32'h2003, 32'h2004, 32'h2006, 32'h0, 4'b1000, 4'b0011, 4'b1100, 4'h0);
    v[2] = mk(32'h30C8, 8'd3, 3'd2, 2'b10, 1'b0, 4'd4,
              32'h30C8, 32'h30CC, 32'h30C0, 32'h30C4, 4'hF, 4'hF, 4'hF, 4'hF);
    v[3] = mk(32'h4002, 8'd2, 3'd0, 2'b00, 1'b0, 4'd3,
              32'h4002, 32'h4002, 32'h4002, 32'h0, 4'b0100, 4'b0100, 4'b0100, 4'h0);
    v[4] = mk(32'h1FFC, 8'd0, 3'd2, 2'b01, 1'b0, 4'd1,
              32'h1FFC, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    v[5] = mk(32'h5000, 8'd0, 3'd2, 2'b11, 1'b1, 4'd0, '0, '0, '0, '0, '0, '0, '0, '0);
    v[6] = mk(32'h5000, 8'd0, 3'd3, 2'b01, 1'b1, 4'd0, '0, '0, '0, '0, '0, '0, '0, '0);
    v[7] = mk(32'h0FF8, 8'd3, 3'd2, 2'b01, 1'b1, 4'd0, '0, '0, '0, '0, '0, '0, '0, '0);
    v[8] = mk(32'h3000, 8'd2, 3'd2, 2'b10, 1'b1, 4'd0, '0, '0, '0, '0, '0, '0, '0, '0);
    v[9] = mk(32'h3002, 8'd1, 3'd2, 2'b10, 1'b1, 4'd0, '0, '0, '0, '0, '0, '0, '0, '0);

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_req_ready", 32'(o_req_ready), 32'd1);
    chk("rst_req_err",   32'(o_req_err), 32'd0);
    chk("rst_beat_valid", 32'(o_beat_valid), 32'd0);
    chk("rst_beat_addr", o_beat_addr, 32'd0);
    chk("rst_beat_strb", 32'(o_beat_strb), 32'd0);
    chk("rst_beat_last", 32'(o_beat_last), 32'd0);
    i_reset = 1'b0;

    for (int k = 0; k < 10; k++) begin
      send(v[k]);
      if (v[k].err) begin
        @(negedge i_clk);
        chk("err_pulse", 32'(o_req_err), 32'd1);
        chk("err_no_beat", 32'(o_beat_valid), 32'd0);
        @(negedge i_clk);
        chk("err_one_cycle", 32'(o_req_err), 32'd0);
        chk("err_still_idle", 32'(o_beat_valid), 32'd0);
      end else begin
        for (int b = 0; b < int'(v[k].nb); b++) expect_beat(v[k], b);
        @(negedge i_clk);
        chk("idle_after_burst", 32'(o_beat_valid), 32'd0);
      end
    end

    // WRAP with stalls: outputs must hold on the current beat while not ready.
    i_beat_ready = 1'b0;
    send(v[2]);
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 20) begin
      @(negedge i_clk);
      chk("stall_valid", 32'(o_beat_valid), 32'd1);
      chk("stall_addr", o_beat_addr, v[2].ea[idx]);
      chk("stall_strb", 32'(o_beat_strb), 32'(v[2].es[idx]));
      chk("stall_last", 32'(o_beat_last), 32'(idx == 3));
      i_beat_ready = (cyc % 2 == 1);
      #1;
      chk("stall_req_ready", 32'(o_req_ready), 32'(i_beat_ready && idx == 3));
      @(posedge i_clk);
      if (i_beat_ready) idx++;
      cyc++;
    end
    if (idx < 4) chk("stall_timeout", 32'(idx), 32'd4);
    i_beat_ready = 1'b1;
    @(negedge i_clk);
    chk("stall_done_idle", 32'(o_beat_valid), 32'd0);

    // Back-to-back: next descriptor presented alongside the last beat.
    send(v[0]);
    for (int b = 0; b < 4; b++) expect_beat(v[0], b);
    drive_req(v[1]);
    #1;
    chk("b2b_req_ready", 32'(o_req_ready), 32'd1);
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    for (int b = 0; b < 3; b++) expect_beat(v[1], b);
    @(negedge i_clk);
    chk("b2b_idle", 32'(o_beat_valid), 32'd0);

    // Reset during the second beat of an 8-beat INCR burst.
    send(mk(32'h6000, 8'd7, 3'd2, 2'b01, 1'b0, 4'd8,
            32'h6000, 32'h6004, 32'h6008, 32'h600C, 4'hF, 4'hF, 4'hF, 4'hF));
    @(negedge i_clk);
    chk("rb_beat0_addr", o_beat_addr, 32'h6000);
    @(negedge i_clk);
    chk("rb_beat1_addr", o_beat_addr, 32'h6004);
    chk("rb_beat1_last", 32'(o_beat_last), 32'd0);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("rb_valid", 32'(o_beat_valid), 32'd0);
    chk("rb_req_ready", 32'(o_req_ready), 32'd1);
    chk("rb_addr", o_beat_addr, 32'd0);
    i_reset = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      chk("rb_no_more_beats", 32'(o_beat_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
